fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Instruction-fetch controller for the single-cycle RISC-V core.
- Owns the fetch PC and drives the combinational instruction memory (16-bit byte address in, 32-bit word out, same-cycle data).
- Registers each fetched word with its PC into a one-entry output stage that uses a valid/ready handshake toward decode.
- Handles enable, branch/jump redirect, and misaligned-target faults.

Parameters:
- PC_W, 16, fetch address width; matches the instruction memory address.
- INSTR_W, 32, instruction word width.
- RESET_PC, 16'h0000, fetch PC loaded at reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- fetch_en  input  1  permission to issue new fetches.
- redirect_valid  input  1  one-cycle pulse: load redirect_pc and flush.
- redirect_pc  input  PC_W  redirect target (byte address).
- imem_pc  output  PC_W  address to instruction memory; equals the fetch PC register.
- imem_instr  input  INSTR_W  word returned combinationally for imem_pc.
- out_valid  output  1  output stage holds a valid instruction.
- out_ready  input  1  decode accepts the instruction this cycle.
- out_instr  output  INSTR_W  registered instruction.
- out_pc  output  PC_W  PC of out_instr.
- fault  output  1  sticky: misaligned redirect target seen.
- fetch_count  output  16  number of completed handoffs (out_valid & out_ready), wraps.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - fpc=RESET_PC, state=IDLE.
  - out_valid=0, out_instr=0, out_pc=0, fault=0, fetch_count=0.
- States:
  - IDLE: after reset; no fetches issued. Moves to RUN on the first cycle with fetch_en=1.
  - RUN: normal fetching.
  - FAULT: terminal. out_valid forced 0. Only rst_n leaves it.
- Signal definitions:
  - accept = out_valid & out_ready.
  - slot_free = ~out_valid | accept.
- RUN, no redirect, fetch_en=1, slot_free=1, on the next edge:
  - out_instr<=imem_instr, out_pc<=fpc, out_valid<=1.
  - fpc<=fpc+4, modulo 2^PC_W (16'hFFFC wraps to 16'h0000).
- RUN, fetch_en=0 or slot_free=0:
  - fpc holds.
  - If accept, out_valid<=0. Otherwise the output stage holds stable (out_instr/out_pc unchanged while out_valid & ~out_ready).
- Throughput and latency:
  - Sustained 1 instruction/cycle when out_ready is held 1.
  - First out_valid appears 1 cycle after entering RUN with fetch_en=1.
- Redirect (redirect_valid=1 in IDLE or RUN) takes priority over fetch and stall:
  - Next edge: out_valid<=0; any held instruction is discarded, even if accepted that same cycle.
  - fpc<=redirect_pc.
  - In IDLE, state stays IDLE unless fetch_en=1.
  - Redirect applies regardless of fetch_en.
- Misaligned redirect (redirect_pc[1:0]!=0):
  - fpc is not updated.
  - fault<=1, state<=FAULT, out_valid<=0.
- fetch_count increments on every accept, including an accept in the same cycle as a redirect.
- Simultaneous redirect and accept in RUN: the count increments, then the flush applies; no new fetch that cycle.
- fetch_en deasserted mid-stream: the in-flight output entry remains until accepted; no new fetch.
- Reset mid-operation: all state returns to reset values immediately; no partial handoff.
- imem_pc is purely the register value; no combinational path from redirect_pc to imem_pc.

Decomposition:
- Shared package fetch_pkg holds:
  - state enum {IDLE, RUN, FAULT}
  - PC_INC=4
  - RESET_PC default
  - PC_W and INSTR_W localparams, reused by the instruction memory and decode.
- Single module, no sub-module. The output register stage is simple enough to stay inline.

Test Plan:
- Reset, then fetch_en=1, out_ready=1 with the 4-word program (0x00 FFC4A303, 0x04 0064A423, 0x08 0062E233, 0x0C FE420AE3) -> out_pc 0x00, 0x04, 0x08, 0x0C on consecutive cycles with matching out_instr; fetch_count=4.
- Backpressure: out_ready=0 for 3 cycles while out_pc=0x04 -> out_instr stays 0064A423 and imem_pc stays 0x08; after release, 0x08 follows next cycle.
- Redirect at the beq: redirect_valid=1, redirect_pc=0x0000 while out_pc=0x0C -> out_valid=0 next cycle, then out_pc=0x00/FFC4A303; no 0x10 entry ever appears.
- Misaligned redirect_pc=0x0006 -> fault=1, out_valid=0 permanently, fpc unchanged; rst_n pulse clears fault and fpc returns to 0x0000.
- Wrap: redirect to 0xFFFC, run 2 fetches -> out_pc 0xFFFC then 0x0000.
- Async reset asserted mid-stream between clock edges -> all outputs zero immediately without waiting for clk; state IDLE; no fetch until fetch_en=1.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-side definitions: address/word widths, reset PC and sequencer states.
// The instruction memory and decode reuse the widths.
package fetch_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 32;
  localparam int PC_INC  = 4;
  localparam logic [PC_W-1:0] RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch PC owner and one-entry valid/ready output stage toward decode.
// Handles enable, redirect flushes and the sticky misaligned-target fault.
module fetch_sequencer #(
  parameter int PC_W    = fetch_pkg::PC_W,
  parameter int INSTR_W = fetch_pkg::INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = fetch_pkg::RESET_PC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    imem_pc,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic               fault,
  output logic [15:0]        fetch_count
);

  import fetch_pkg::*;

  state_t               state, state_next;
  logic [PC_W-1:0]      fpc, fpc_next;
  logic                 valid_next;
  logic [INSTR_W-1:0]   instr_next;
  logic [PC_W-1:0]      pc_next;
  logic                 fault_next;
  logic [15:0]          count_next;
  logic                 accept;
  logic                 slot_free;
  logic                 misaligned;

  assign accept     = out_valid & out_ready;
  assign slot_free  = ~out_valid | accept;
  assign misaligned = redirect_pc[1:0] != 2'b00;
  assign imem_pc    = fpc;

  always_comb begin
    state_next = state;
    fpc_next   = fpc;
    valid_next = out_valid;
    instr_next = out_instr;
    pc_next    = out_pc;
    fault_next = fault;
    count_next = fetch_count + {15'd0, accept};

    case (state)
      IDLE: begin
        if (redirect_valid && misaligned) begin
          fault_next = 1'b1;
          valid_next = 1'b0;
          state_next = FAULT;
        end else begin
          if (redirect_valid) begin
            fpc_next   = redirect_pc;
            valid_next = 1'b0;
          end
          if (fetch_en) begin
            state_next = RUN;
          end
        end
      end

      RUN: begin
        if (redirect_valid) begin
          // Flush wins over fetch; an accept this cycle is still counted above.
          valid_next = 1'b0;
          if (misaligned) begin
            fault_next = 1'b1;
            state_next = FAULT;
          end else begin
            fpc_next = redirect_pc;
          end
        end else if (fetch_en && slot_free) begin
          instr_next = imem_instr;
          pc_next    = fpc;
          valid_next = 1'b1;
          fpc_next   = fpc + PC_W'(PC_INC);
        end else if (accept) begin
          valid_next = 1'b0;
        end
      end

      FAULT: begin
        valid_next = 1'b0;
      end

      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      fpc         <= RESET_PC;
      out_valid   <= 1'b0;
      out_instr   <= '0;
      out_pc      <= '0;
      fault       <= 1'b0;
      fetch_count <= 16'd0;
    end else begin
      state       <= state_next;
      fpc         <= fpc_next;
      out_valid   <= valid_next;
      out_instr   <= instr_next;
      out_pc      <= pc_next;
      fault       <= fault_next;
      fetch_count <= count_next;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus random traffic
// scored every cycle against a transaction-level model of the fetch stream.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [15:0] imem_pc;
  logic [31:0] imem_instr;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [15:0] out_pc;
  logic        fault;
  logic [15:0] fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the program stream as the decoder should see it.
  bit          m_started;
  bit          m_fault;
  int          m_fpc;
  bit          m_valid;
  logic [31:0] m_instr;
  int          m_pc;
  int          m_count;
  bit          seen_0x10;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [15:0] a);
    case (a)
      16'h0000: imem_word = 32'hFFC4A303;
      16'h0004: imem_word = 32'h0064A423;
      16'h0008: imem_word = 32'h0062E233;
      16'h000C: imem_word = 32'hFE420AE3;
      default:  imem_word = {a, ~a};
    endcase
  endfunction

  assign imem_instr = imem_word(imem_pc);

  fetch_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fault          (fault),
    .fetch_count    (fetch_count)
  );

  task automatic model_reset();
    m_started = 0; m_fault = 0; m_fpc = 0; m_valid = 0;
    m_instr = 32'h0; m_pc = 0; m_count = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
    #3;
    rst_n = 1'b1;
    model_reset();
  endtask

  // Advance one clock: predict from current inputs, then score every output.
  task automatic tick();
    bit handoff;
    handoff = m_valid && out_ready;
    if (!m_fault) begin
      if (handoff) m_count = (m_count + 1) % 65536;
      if (redirect_valid) begin
        m_valid = 0;
        if (redirect_pc % 4 != 0) m_fault = 1;
        else begin
          m_fpc = redirect_pc;
          if (fetch_en) m_started = 1;
        end
      end else if (!m_started) begin
        if (fetch_en) m_started = 1;
      end else if (fetch_en && (!m_valid || out_ready)) begin
        m_instr = imem_word(16'(m_fpc));
        m_pc    = m_fpc;
        m_valid = 1;
        m_fpc   = (m_fpc + 4) % 65536;
      end else if (handoff) begin
        m_valid = 0;
      end
    end
    if (handoff) $display("handoff pc=%h instr=%h", out_pc, out_instr);
    @(posedge clk); #1;
    if (out_valid && out_pc == 16'h0010) seen_0x10 = 1;
    n_checks++;
    if (out_valid !== m_valid) begin
      n_fail++; $display("FAIL out_valid got %b want %b at %0t", out_valid, m_valid, $time);
    end
    n_checks++;
    if (out_pc !== 16'(m_pc) || out_instr !== m_instr) begin
      n_fail++; $display("FAIL out_entry got %h/%h want %h/%h", out_pc, out_instr, 16'(m_pc), m_instr);
    end
    n_checks++;
    if (imem_pc !== 16'(m_fpc)) begin
      n_fail++; $display("FAIL imem_pc got %h want %h", imem_pc, 16'(m_fpc));
    end
    n_checks++;
    if (fault !== m_fault || fetch_count !== 16'(m_count)) begin
      n_fail++; $display("FAIL fault_count got %b/%0d want %b/%0d", fault, fetch_count, m_fault, m_count);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({out_valid, out_instr, out_pc, fault, fetch_count, imem_pc} !== 82'h0) begin
      n_fail++; $display("FAIL reset_state got v=%b i=%h p=%h f=%b c=%0d a=%h want all zero",
                         out_valid, out_instr, out_pc, fault, fetch_count, imem_pc);
    end
    fetch_en = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (out_valid !== 1'b0 || imem_pc !== 16'h0000) begin
      n_fail++; $display("FAIL idle_no_fetch got v=%b a=%h want 0/0000", out_valid, imem_pc);
    end
  endtask

  task automatic test_program();
    logic [15:0] pcs [4];
    logic [31:0] words [4];
    pcs = '{16'h0000, 16'h0004, 16'h0008, 16'h000C};
    words = '{32'hFFC4A303, 32'h0064A423, 32'h0062E233, 32'hFE420AE3};
    do_reset();
    fetch_en = 1'b1; out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL enter_run_latency got v=%b want 0", out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== pcs[i] || out_instr !== words[i]) begin
        n_fail++; $display("FAIL prog_word%0d got v=%b %h/%h want 1 %h/%h",
                           i, out_valid, out_pc, out_instr, pcs[i], words[i]);
      end
    end
    fetch_en = 1'b0;
    tick();
    n_checks++;
    if (fetch_count !== 16'd4 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL prog_count got %0d v=%b want 4 v=0", fetch_count, out_valid);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    fetch_en = 1'b1; out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (out_pc !== 16'h0004 || out_instr !== 32'h0064A423 || imem_pc !== 16'h0008 || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold%0d got %h/%h a=%h want 0004/0064a423 a=0008", i, out_pc, out_instr, imem_pc);
      end
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_pc !== 16'h0008 || out_instr !== 32'h0062E233) begin
      n_fail++; $display("FAIL bp_release got %h/%h want 0008/0062e233", out_pc, out_instr);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    seen_0x10 = 0;
    fetch_en = 1'b1; out_ready = 1'b1;
    repeat (5) tick();
    redirect_valid = 1'b1; redirect_pc = 16'h0000;
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || fetch_count !== 16'd4) begin
      n_fail++; $display("FAIL redirect_flush got v=%b c=%0d want 0 4", out_valid, fetch_count);
    end
    tick();
    n_checks++;
    if (out_pc !== 16'h0000 || out_instr !== 32'hFFC4A303 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL redirect_target got %h/%h want 0000/ffc4a303", out_pc, out_instr);
    end
    repeat (2) tick();
    n_checks++;
    if (seen_0x10) begin
      n_fail++; $display("FAIL redirect_no_0x10 got seen=1 want 0");
    end
  endtask

  task automatic test_misaligned();
    logic [15:0] held;
    do_reset();
    fetch_en = 1'b1; out_ready = 1'b1;
    repeat (3) tick();
    held = imem_pc;
    redirect_valid = 1'b1; redirect_pc = 16'h0006;
    tick();
    redirect_valid = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (fault !== 1'b1 || out_valid !== 1'b0 || imem_pc !== held) begin
      n_fail++; $display("FAIL misaligned got f=%b v=%b a=%h want 1 0 %h", fault, out_valid, imem_pc, held);
    end
    do_reset();
    n_checks++;
    if (fault !== 1'b0 || imem_pc !== 16'h0000) begin
      n_fail++; $display("FAIL fault_clear got f=%b a=%h want 0 0000", fault, imem_pc);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    fetch_en = 1'b1; out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 16'hFFFC;
    tick();
    redirect_valid = 1'b0;
    tick();
    n_checks++;
    if (out_pc !== 16'hFFFC || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL wrap_first got %h v=%b want fffc 1", out_pc, out_valid);
    end
    tick();
    n_checks++;
    if (out_pc !== 16'h0000 || out_instr !== 32'hFFC4A303) begin
      n_fail++; $display("FAIL wrap_second got %h/%h want 0000/ffc4a303", out_pc, out_instr);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    fetch_en = 1'b1; out_ready = 1'b1;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_instr, out_pc, fault, fetch_count, imem_pc} !== 82'h0) begin
      n_fail++; $display("FAIL async_reset got v=%b i=%h p=%h c=%0d a=%h want all zero",
                         out_valid, out_instr, out_pc, fetch_count, imem_pc);
    end
    fetch_en = 1'b0;
    #1 rst_n = 1'b1;
    model_reset();
    repeat (3) tick();
    fetch_en = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (out_pc !== 16'h0004) begin
      n_fail++; $display("FAIL async_restart got %h want 0004", out_pc);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      fetch_en  = ($urandom_range(0, 9) < 8);
      out_ready = ($urandom_range(0, 9) < 6);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc = 16'($urandom_range(0, 16'h3FFF)) << 2;
      if (i > 560 && $urandom_range(0, 9) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
      tick();
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    fetch_en = 1'b1; out_ready = 1'b1;
    repeat (20) tick();
    n_checks++;
    if (fetch_count !== 16'd18) begin
      n_fail++; $display("FAIL b2b_throughput got %0d want 18", fetch_count);
    end
  endtask

  initial begin
    test_reset();
    test_program();
    test_backpressure();
    test_redirect();
    test_misaligned();
    test_wrap();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
